lc3_control: RTL and testbench

- Microsequencer FSM that drives every control input of the LC3 datapath: register loads, bus gates, mux selects, ALU op and memory strobes.
- Observes the IR register output and the shared 16-bit bus.
- Keeps the N/Z/P condition codes internally.
- Implements fetch, decode and execute for the LC3 instruction set, excluding RTI.

---
 rtl/lc3_control.sv | 248 ++++++++++++++++++++++++
 tb/tb_lc3_control.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control.sv
// LC3 microsequencer: fetch/decode/execute FSM driving every datapath control input.
// Keeps the N/Z/P condition codes; RTI and the reserved opcode park the machine in HALT.
module lc3_control #(
   parameter int         MEM_LAT   = 0,
   parameter logic [1:0] ALUK_ADD  = 2'b10,
   parameter logic [1:0] ALUK_AND  = 2'b01,
   parameter logic [1:0] ALUK_NOT  = 2'b00,
   parameter logic [1:0] ALUK_PASS = 2'b11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic [15:0] bus,
   output logic        ld_ir,
   output logic        ld_reg,
   output logic        ld_pc,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic [2:0]  dr,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2,
   output logic [1:0]  aluk,
   output logic        gate_alu,
   output logic        gate_pc,
   output logic        gate_marmux,
   output logic        gate_mdr,
   output logic        a1m_sel,
   output logic [1:0]  a2m_sel,
   output logic [1:0]  pcmux_sel,
   output logic        marmux_sel,
   output logic        mem_en,
   output logic        mem_rw,
   output logic        halted,
   output logic [2:0]  cc
);

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   localparam logic [4:0] S_F1     = 5'd0;
   localparam logic [4:0] S_MR     = 5'd1;
   localparam logic [4:0] S_F3     = 5'd2;
   localparam logic [4:0] S_DEC    = 5'd3;
   localparam logic [4:0] S_ALU    = 5'd4;
   localparam logic [4:0] S_BR_T   = 5'd5;
   localparam logic [4:0] S_JMP    = 5'd6;
   localparam logic [4:0] S_JSR    = 5'd7;
   localparam logic [4:0] S_ADDR   = 5'd8;
   localparam logic [4:0] S_RELOAD = 5'd9;
   localparam logic [4:0] S_LD_FIN = 5'd10;
   localparam logic [4:0] S_ST_DAT = 5'd11;
   localparam logic [4:0] S_MW     = 5'd12;
   localparam logic [4:0] S_LEA    = 5'd13;
   localparam logic [4:0] S_T1     = 5'd14;
   localparam logic [4:0] S_T2     = 5'd15;
   localparam logic [4:0] S_T4     = 5'd16;
   localparam logic [4:0] S_HALT   = 5'd17;

   logic [4:0] state_r, state_nxt_s;
   logic [4:0] mr_ret_r, mr_ret_nxt_s;
   logic [2:0] wait_cnt_r, wait_cnt_nxt_s;
   logic [2:0] cc_r;
   logic [3:0] opcode_s;
   logic       br_taken_s;
   logic       mem_last_s;
   logic       cc_upd_s;
   logic       ir_unused_s;

   function automatic logic [2:0] cc_of(input logic [15:0] v);
      if (v[15]) begin
         cc_of = 3'b100;
      end else if (v == 16'h0000) begin
         cc_of = 3'b010;
      end else begin
         cc_of = 3'b001;
      end
   endfunction

   assign opcode_s    = ir[15:12];
   assign br_taken_s  = |(ir[11:9] & cc_r);
   assign mem_last_s  = (wait_cnt_r == LAT);
   assign cc_upd_s    = (state_r == S_ALU) || (state_r == S_LD_FIN);
   assign ir_unused_s = ^ir[5:3];
   assign cc          = cc_r;

   // Next-state, wait-counter and post-read return-target selection.
   always_comb begin
      state_nxt_s    = state_r;
      mr_ret_nxt_s   = mr_ret_r;
      wait_cnt_nxt_s = 3'd0;
      case (state_r)
         S_F1: begin
            state_nxt_s  = S_MR;
            mr_ret_nxt_s = S_F3;
         end
         S_MR: begin
            if (mem_last_s) begin
               state_nxt_s = mr_ret_r;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + 3'd1;
            end
         end
         S_F3: state_nxt_s = S_DEC;
         S_DEC: begin
            case (opcode_s)
               4'b0000: state_nxt_s = br_taken_s ? S_BR_T : S_F1;
               4'b0001, 4'b0101, 4'b1001: state_nxt_s = S_ALU;
               4'b0010, 4'b0110, 4'b1010,
               4'b0011, 4'b0111, 4'b1011: state_nxt_s = S_ADDR;
               4'b1100: state_nxt_s = S_JMP;
               4'b0100: state_nxt_s = S_JSR;
               4'b1110: state_nxt_s = S_LEA;
               4'b1111: state_nxt_s = (ir[7:0] == 8'h25) ? S_HALT : S_T1;
               default: state_nxt_s = S_HALT;
            endcase
         end
         // ir[15] marks the indirect forms, ir[12] the stores.
         S_ADDR: begin
            if (!ir[12] || ir[15]) begin
               state_nxt_s  = S_MR;
               mr_ret_nxt_s = ir[15] ? S_RELOAD : S_LD_FIN;
            end else begin
               state_nxt_s = S_ST_DAT;
            end
         end
         S_RELOAD: begin
            state_nxt_s  = S_MR;
            mr_ret_nxt_s = ir[12] ? S_ST_DAT : S_LD_FIN;
         end
         S_ST_DAT: state_nxt_s = S_MW;
         S_MW: begin
            if (mem_last_s) begin
               state_nxt_s = S_F1;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + 3'd1;
            end
         end
         S_T1: state_nxt_s = S_T2;
         S_T2: begin
            state_nxt_s  = S_MR;
            mr_ret_nxt_s = S_T4;
         end
         S_HALT: state_nxt_s = S_HALT;
         default: state_nxt_s = S_F1;
      endcase
   end

   // State, wait counter and condition-code registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_F1;
         mr_ret_r   <= S_F3;
         wait_cnt_r <= 3'd0;
         cc_r       <= 3'b010;
      end else begin
         state_r    <= state_nxt_s;
         mr_ret_r   <= mr_ret_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         if (cc_upd_s) begin
            cc_r <= cc_of(bus);
         end else begin
            cc_r <= cc_r;
         end
      end
   end

   // Control outputs decoded from the current state and ir; all quiet during reset.
   always_comb begin
      ld_ir = 1'b0;  ld_reg = 1'b0;  ld_pc = 1'b0;  ld_mar = 1'b0;  ld_mdr = 1'b0;
      dr = 3'd0;  sr1 = 3'd0;  sr2 = 3'd0;  aluk = 2'b00;
      gate_alu = 1'b0;  gate_pc = 1'b0;  gate_marmux = 1'b0;  gate_mdr = 1'b0;
      a1m_sel = 1'b0;  a2m_sel = 2'd0;  pcmux_sel = 2'd0;  marmux_sel = 1'b0;
      mem_en = 1'b0;  mem_rw = 1'b0;  halted = 1'b0;
      if (!rst) begin
         case (state_r)
            S_F1: begin
               gate_pc = 1'b1;  ld_mar = 1'b1;  ld_pc = 1'b1;  pcmux_sel = 2'd2;
            end
            S_MR: begin
               mem_en = 1'b1;
               ld_mdr = mem_last_s;
            end
            S_F3: begin
               gate_mdr = 1'b1;  ld_ir = 1'b1;
            end
            S_ALU: begin
               gate_alu = 1'b1;  ld_reg = 1'b1;
               dr = ir[11:9];  sr1 = ir[8:6];  sr2 = ir[2:0];
               case (opcode_s)
                  4'b0001: aluk = ALUK_ADD;
                  4'b0101: aluk = ALUK_AND;
                  default: aluk = ALUK_NOT;
               endcase
            end
            S_BR_T: begin
               ld_pc = 1'b1;  pcmux_sel = 2'd1;  a1m_sel = 1'b1;  a2m_sel = 2'd1;
            end
            S_JMP: begin
               ld_pc = 1'b1;  pcmux_sel = 2'd1;  a2m_sel = 2'd3;  sr1 = ir[8:6];
            end
            // Old PC reaches R7 over the bus in the same edge the new PC loads.
            S_JSR: begin
               gate_pc = 1'b1;  ld_reg = 1'b1;  dr = 3'd7;  ld_pc = 1'b1;  pcmux_sel = 2'd1;
               if (ir[11]) begin
                  a1m_sel = 1'b1;  a2m_sel = 2'd0;
               end else begin
                  a2m_sel = 2'd3;  sr1 = ir[8:6];
               end
            end
            S_ADDR: begin
               gate_marmux = 1'b1;  marmux_sel = 1'b1;  ld_mar = 1'b1;
               if (ir[14]) begin
                  a2m_sel = 2'd2;  sr1 = ir[8:6];
               end else begin
                  a1m_sel = 1'b1;  a2m_sel = 2'd1;
               end
            end
            S_RELOAD: begin
               gate_mdr = 1'b1;  ld_mar = 1'b1;
            end
            S_LD_FIN: begin
               gate_mdr = 1'b1;  ld_reg = 1'b1;  dr = ir[11:9];
            end
            S_ST_DAT: begin
               gate_alu = 1'b1;  aluk = ALUK_PASS;  sr1 = ir[11:9];  ld_mdr = 1'b1;
            end
            S_MW: mem_rw = 1'b1;
            S_LEA: begin
               gate_marmux = 1'b1;  marmux_sel = 1'b1;  a1m_sel = 1'b1;  a2m_sel = 2'd1;
               ld_reg = 1'b1;  dr = ir[11:9];
            end
            S_T1: begin
               gate_pc = 1'b1;  ld_reg = 1'b1;  dr = 3'd7;
            end
            S_T2: begin
               gate_marmux = 1'b1;  ld_mar = 1'b1;
            end
            S_T4: begin
               gate_mdr = 1'b1;  ld_pc = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: halted = 1'b0;
         endcase
      end else begin
         halted = 1'b0;
      end
   end

endmodule

// File: tb/tb_lc3_control.sv
// Directed, table-driven bench for lc3_control: one instance with MEM_LAT=0, one with MEM_LAT=2.
module tb_lc3_control;

   typedef struct packed {
      logic       ld_ir, ld_reg, ld_pc, ld_mar, ld_mdr;
      logic [2:0] dr, sr1, sr2;
      logic [1:0] aluk;
      logic       gate_alu, gate_pc, gate_marmux, gate_mdr;
      logic       a1m_sel;
      logic [1:0] a2m_sel, pcmux_sel;
      logic       marmux_sel, mem_en, mem_rw, halted;
      logic [2:0] cc;
   } outs_t;

   typedef struct {
      string       name;
      logic        rst;
      logic        sel;
      logic [15:0] ir;
      logic [15:0] bus;
      outs_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ir  = 16'h0000;
   logic [15:0] bus = 16'h0000;
   outs_t       o0, o2;
   vec_t        vq[$];
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   lc3_control #(.MEM_LAT(0)) u_lat0 (
      .clk(clk), .rst(rst), .ir(ir), .bus(bus),
      .ld_ir(o0.ld_ir), .ld_reg(o0.ld_reg), .ld_pc(o0.ld_pc), .ld_mar(o0.ld_mar), .ld_mdr(o0.ld_mdr),
      .dr(o0.dr), .sr1(o0.sr1), .sr2(o0.sr2), .aluk(o0.aluk),
      .gate_alu(o0.gate_alu), .gate_pc(o0.gate_pc), .gate_marmux(o0.gate_marmux), .gate_mdr(o0.gate_mdr),
      .a1m_sel(o0.a1m_sel), .a2m_sel(o0.a2m_sel), .pcmux_sel(o0.pcmux_sel), .marmux_sel(o0.marmux_sel),
      .mem_en(o0.mem_en), .mem_rw(o0.mem_rw), .halted(o0.halted), .cc(o0.cc)
   );

   lc3_control #(.MEM_LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .ir(ir), .bus(bus),
      .ld_ir(o2.ld_ir), .ld_reg(o2.ld_reg), .ld_pc(o2.ld_pc), .ld_mar(o2.ld_mar), .ld_mdr(o2.ld_mdr),
      .dr(o2.dr), .sr1(o2.sr1), .sr2(o2.sr2), .aluk(o2.aluk),
      .gate_alu(o2.gate_alu), .gate_pc(o2.gate_pc), .gate_marmux(o2.gate_marmux), .gate_mdr(o2.gate_mdr),
      .a1m_sel(o2.a1m_sel), .a2m_sel(o2.a2m_sel), .pcmux_sel(o2.pcmux_sel), .marmux_sel(o2.marmux_sel),
      .mem_en(o2.mem_en), .mem_rw(o2.mem_rw), .halted(o2.halted), .cc(o2.cc)
   );

   function automatic outs_t e0(input logic [2:0] c);
      outs_t r;
      r    = '0;
      r.cc = c;
      return r;
   endfunction

   function automatic outs_t e_f1(input logic [2:0] c);
      outs_t r;
      r = e0(c);
      r.gate_pc = 1'b1;  r.ld_mar = 1'b1;  r.ld_pc = 1'b1;  r.pcmux_sel = 2'd2;
      return r;
   endfunction

   task automatic add(input string n, input logic r, input logic s, input logic [15:0] i,
                      input logic [15:0] b, input outs_t e);
      vec_t v;
      v.name = n;  v.rst = r;  v.sel = s;  v.ir = i;  v.bus = b;  v.exp = e;
      vq.push_back(v);
   endtask

   task automatic add_mr(input string n, input logic s, input logic [15:0] i,
                         input logic [2:0] c, input int lat);
      outs_t x;
      for (int k = 0; k <= lat; k++) begin
         x = e0(c);
         x.mem_en = 1'b1;
         x.ld_mdr = (k == lat);
         add($sformatf("%s_mr%0d", n, k), 1'b0, s, i, 16'h0000, x);
      end
   endtask

   task automatic add_fetch(input string n, input logic s, input logic [15:0] i,
                            input logic [2:0] c, input int lat);
      outs_t x;
      add({n, "_f1"}, 1'b0, s, i, 16'h0000, e_f1(c));
      add_mr({n, "_fetch"}, s, i, c, lat);
      x = e0(c);  x.gate_mdr = 1'b1;  x.ld_ir = 1'b1;
      add({n, "_f3"}, 1'b0, s, i, 16'h0000, x);
      add({n, "_dec"}, 1'b0, s, i, 16'h0000, e0(c));
   endtask

   task automatic check(input string n, input outs_t act, input outs_t exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h required %h", n, act, exp);
      end
   endtask

   // Apply every queued vector one cycle each, compare at the falling edge, then empty the queue.
   task automatic run_queue();
      foreach (vq[k]) begin
         rst = vq[k].rst;  ir = vq[k].ir;  bus = vq[k].bus;
         @(negedge clk);
         check(vq[k].name, vq[k].sel ? o2 : o0, vq[k].exp);
         @(posedge clk);
         #1;
      end
      vq.delete();
   endtask

   initial begin
      outs_t x;
      repeat (2) @(posedge clk);
      #1;

      // ---- MEM_LAT=0 instruction stream ----
      add("reset", 1'b1, 1'b0, 16'h0000, 16'h0000, e0(3'b010));
      add_fetch("add", 1'b0, 16'h12BF, 3'b010, 0);
      x = e0(3'b010);  x.gate_alu = 1'b1;  x.ld_reg = 1'b1;  x.dr = 3'd1;  x.sr1 = 3'd2;
      x.sr2 = 3'd7;  x.aluk = 2'b10;
      add("add_exec", 1'b0, 1'b0, 16'h12BF, 16'hFFFF, x);
      add_fetch("and", 1'b0, 16'h5020, 3'b100, 0);
      x = e0(3'b100);  x.gate_alu = 1'b1;  x.ld_reg = 1'b1;  x.aluk = 2'b01;
      add("and_exec", 1'b0, 1'b0, 16'h5020, 16'h0000, x);
      add_fetch("brz_t", 1'b0, 16'h0405, 3'b010, 0);
      x = e0(3'b010);  x.ld_pc = 1'b1;  x.pcmux_sel = 2'd1;  x.a1m_sel = 1'b1;  x.a2m_sel = 2'd1;
      add("brz_taken", 1'b0, 1'b0, 16'h0405, 16'h0000, x);
      add_fetch("add1", 1'b0, 16'h1261, 3'b010, 0);
      x = e0(3'b010);  x.gate_alu = 1'b1;  x.ld_reg = 1'b1;  x.dr = 3'd1;  x.sr1 = 3'd1;
      x.sr2 = 3'd1;  x.aluk = 2'b10;
      add("add1_exec", 1'b0, 1'b0, 16'h1261, 16'h0001, x);
      add_fetch("brz_nt", 1'b0, 16'h0405, 3'b001, 0);
      add_fetch("str_after_brnt", 1'b0, 16'h7941, 3'b001, 0);
      x = e0(3'b001);  x.gate_marmux = 1'b1;  x.marmux_sel = 1'b1;  x.ld_mar = 1'b1;
      x.a2m_sel = 2'd2;  x.sr1 = 3'd5;
      add("str_addr", 1'b0, 1'b0, 16'h7941, 16'h0000, x);
      x = e0(3'b001);  x.gate_alu = 1'b1;  x.aluk = 2'b11;  x.sr1 = 3'd4;  x.ld_mdr = 1'b1;
      add("str_data", 1'b0, 1'b0, 16'h7941, 16'h0000, x);
      x = e0(3'b001);  x.mem_rw = 1'b1;
      add("str_mw", 1'b0, 1'b0, 16'h7941, 16'h0000, x);
      add_fetch("jmp", 1'b0, 16'hC0C0, 3'b001, 0);
      x = e0(3'b001);  x.ld_pc = 1'b1;  x.pcmux_sel = 2'd1;  x.a2m_sel = 2'd3;  x.sr1 = 3'd3;
      add("jmp_exec", 1'b0, 1'b0, 16'hC0C0, 16'h0000, x);
      add_fetch("jsr", 1'b0, 16'h4805, 3'b001, 0);
      x = e0(3'b001);  x.gate_pc = 1'b1;  x.ld_reg = 1'b1;  x.dr = 3'd7;  x.ld_pc = 1'b1;
      x.pcmux_sel = 2'd1;  x.a1m_sel = 1'b1;
      add("jsr_exec", 1'b0, 1'b0, 16'h4805, 16'h8000, x);
      add_fetch("jsrr", 1'b0, 16'h4080, 3'b001, 0);
      x = e0(3'b001);  x.gate_pc = 1'b1;  x.ld_reg = 1'b1;  x.dr = 3'd7;  x.ld_pc = 1'b1;
      x.pcmux_sel = 2'd1;  x.a2m_sel = 2'd3;  x.sr1 = 3'd2;
      add("jsrr_exec", 1'b0, 1'b0, 16'h4080, 16'h8000, x);
      add_fetch("lea", 1'b0, 16'hEC03, 3'b001, 0);
      x = e0(3'b001);  x.gate_marmux = 1'b1;  x.marmux_sel = 1'b1;  x.a1m_sel = 1'b1;
      x.a2m_sel = 2'd1;  x.ld_reg = 1'b1;  x.dr = 3'd6;
      add("lea_exec", 1'b0, 1'b0, 16'hEC03, 16'h0000, x);
      add_fetch("not", 1'b0, 16'h94FF, 3'b001, 0);
      x = e0(3'b001);  x.gate_alu = 1'b1;  x.ld_reg = 1'b1;  x.dr = 3'd2;  x.sr1 = 3'd3;
      x.sr2 = 3'd7;  x.aluk = 2'b00;
      add("not_exec", 1'b0, 1'b0, 16'h94FF, 16'h8000, x);
      add_fetch("trap21", 1'b0, 16'hF021, 3'b100, 0);
      x = e0(3'b100);  x.gate_pc = 1'b1;  x.ld_reg = 1'b1;  x.dr = 3'd7;
      add("trap_t1", 1'b0, 1'b0, 16'hF021, 16'h0000, x);
      x = e0(3'b100);  x.gate_marmux = 1'b1;  x.ld_mar = 1'b1;
      add("trap_t2", 1'b0, 1'b0, 16'hF021, 16'h0000, x);
      add_mr("trap", 1'b0, 16'hF021, 3'b100, 0);
      x = e0(3'b100);  x.gate_mdr = 1'b1;  x.ld_pc = 1'b1;
      add("trap_t4", 1'b0, 1'b0, 16'hF021, 16'h0000, x);
      add("trap_done_f1", 1'b0, 1'b0, 16'hF021, 16'h0000, e_f1(3'b100));

      // ---- MEM_LAT=2: LDI R3, two indirect reads of three cycles each ----
      add("reset2", 1'b1, 1'b1, 16'hA602, 16'h0000, e0(3'b010));
      add_fetch("ldi", 1'b1, 16'hA602, 3'b010, 2);
      x = e0(3'b010);  x.gate_marmux = 1'b1;  x.marmux_sel = 1'b1;  x.ld_mar = 1'b1;
      x.a1m_sel = 1'b1;  x.a2m_sel = 2'd1;
      add("ldi_addr", 1'b0, 1'b1, 16'hA602, 16'h0000, x);
      add_mr("ldi_ptr", 1'b1, 16'hA602, 3'b010, 2);
      x = e0(3'b010);  x.gate_mdr = 1'b1;  x.ld_mar = 1'b1;
      add("ldi_reload", 1'b0, 1'b1, 16'hA602, 16'h0000, x);
      add_mr("ldi_data", 1'b1, 16'hA602, 3'b010, 2);
      x = e0(3'b010);  x.gate_mdr = 1'b1;  x.ld_reg = 1'b1;  x.dr = 3'd3;
      add("ldi_final", 1'b0, 1'b1, 16'hA602, 16'h0005, x);
      add("ldi_next_f1", 1'b0, 1'b1, 16'hA602, 16'h0000, e_f1(3'b001));
      run_queue();

      // ---- TRAP x25 parks in HALT; only reset leaves it ----
      add("halt_reset", 1'b1, 1'b0, 16'hF025, 16'h0000, e0(3'b010));
      add_fetch("trap25", 1'b0, 16'hF025, 3'b010, 0);
      run_queue();
      x = e0(3'b010);  x.halted = 1'b1;
      for (int k = 0; k < 20; k++) begin
         add($sformatf("halt_hold%0d", k), 1'b0, 1'b0, 16'hF025, 16'($urandom_range(0, 65535)), x);
      end
      add("halt_rst", 1'b1, 1'b0, 16'hF025, 16'h0000, e0(3'b010));
      add("halt_exit_f1", 1'b0, 1'b0, 16'hF025, 16'h0000, e_f1(3'b010));
      run_queue();

      // ---- RTI decodes to HALT ----
      add("rti_reset", 1'b1, 1'b0, 16'h8000, 16'h0000, e0(3'b010));
      add_fetch("rti", 1'b0, 16'h8000, 3'b010, 0);
      x = e0(3'b010);  x.halted = 1'b1;
      add("rti_halt", 1'b0, 1'b0, 16'h8000, 16'h0000, x);
      run_queue();

      // ---- reset during a read wait cycle aborts cleanly ----
      add("abort_reset", 1'b1, 1'b1, 16'h1261, 16'h0000, e0(3'b010));
      add("abort_f1", 1'b0, 1'b1, 16'h1261, 16'h0000, e_f1(3'b010));
      x = e0(3'b010);  x.mem_en = 1'b1;
      add("abort_mr_wait", 1'b0, 1'b1, 16'h1261, 16'h0000, x);
      add("abort_rst_hi", 1'b1, 1'b1, 16'h1261, 16'h0000, e0(3'b010));
      add("abort_then_f1", 1'b0, 1'b1, 16'h1261, 16'h0000, e_f1(3'b010));
      add("abort_then_mr", 1'b0, 1'b1, 16'h1261, 16'h0000, x);
      run_queue();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
